// File: rtl/ysyx_22040632_div_ctrl.sv
// ysyx_22040632_div_ctrl: sequences RV64M divide/remainder ops onto an iterative divider.
// Ports: op_* / src1 / src2 accept an operation from the EXU (op_sel 00 DIV, 01 DIVU,
// 10 REM, 11 REMU; op_word selects the 32-bit W form); flush abandons it. res_valid/res_data
// return the final result. div_* drive the divider request, abort and result interface.
module ysyx_22040632_div_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [1:0]      op_sel,
  input  logic            op_word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            res_valid,
  output logic [XLEN-1:0] res_data,
  output logic            div_valid,
  input  logic            div_ready,
  output logic            div_signed,
  output logic            div_divw,
  output logic [XLEN-1:0] div_dividend,
  output logic [XLEN-1:0] div_divisor,
  output logic            div_flush,
  input  logic            div_out_valid,
  input  logic [XLEN-1:0] div_quotient,
  input  logic [XLEN-1:0] div_remainder
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CHECK = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  logic [2:0]      state;
  logic [1:0]      sel;
  logic            word;
  logic [XLEN-1:0] a, b, opa, opb, raw, res_next;
  logic            dz, ovf;
  always_comb begin
    opa = word ? XLEN'(a[31:0]) : a;
    opb = word ? XLEN'(b[31:0]) : b;
    dz  = opb == '0;
    ovf = ~sel[0] && (word ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1)
                           : (a == {1'b1, {(XLEN-1){1'b0}}} && b == '1));
    // special results only matter in CHECK; otherwise the divider output is selected
    raw = state == CHECK ? (sel[1] ? (dz ? opa : '0) : (dz ? '1 : opa))
                         : (sel[1] ? div_remainder : div_quotient);
    res_next = word ? {{(XLEN-32){raw[31]}}, raw[31:0]} : raw;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= '0;
      word     <= 1'b0;
      a        <= '0;
      b        <= '0;
      res_data <= '0;
    end else begin
      case (state)
        IDLE: if (op_valid && !flush) begin
          sel   <= op_sel;
          word  <= op_word;
          a     <= src1;
          b     <= src2;
          state <= CHECK;
        end
        CHECK: if (flush) state <= IDLE;
          else if (dz || ovf) begin
            res_data <= res_next;
            state    <= DONE;
          end else state <= ISSUE;
        ISSUE: if (flush) state <= IDLE;
          else if (div_ready) state <= WAIT;
        WAIT: if (flush) state <= IDLE;
          else if (div_out_valid) begin
            res_data <= res_next;
            state    <= DONE;
          end
        default: state <= IDLE;
      endcase
    end
  end
  assign op_ready     = state == IDLE;
  assign res_valid    = state == DONE;
  assign div_valid    = state == ISSUE && !flush;
  assign div_flush    = flush && (state == ISSUE || state == WAIT);
  assign div_signed   = ~sel[0];
  assign div_divw     = word;
  assign div_dividend = opa;
  assign div_divisor  = opb;
endmodule

// File: tb/tb_ysyx_22040632_div_ctrl.sv
// tb_ysyx_22040632_div_ctrl: directed self-checking bench for the divide controller.
module tb_ysyx_22040632_div_ctrl;
  logic        clk = 0, rst_n = 0;
  logic        op_valid = 0, op_ready, op_word = 0, flush = 0;
  logic [1:0]  op_sel = 0;
  logic [63:0] src1 = 0, src2 = 0, res_data, div_dividend, div_divisor;
  logic [63:0] div_quotient = 0, div_remainder = 0;
  logic        res_valid, div_valid, div_ready = 1, div_signed, div_divw, div_flush;
  logic        div_out_valid = 0;
  int tests = 0, fails = 0, vcnt = 0, fcnt = 0;

  ysyx_22040632_div_ctrl #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready), .op_sel(op_sel),
    .op_word(op_word), .src1(src1), .src2(src2), .flush(flush), .res_valid(res_valid),
    .res_data(res_data), .div_valid(div_valid), .div_ready(div_ready),
    .div_signed(div_signed), .div_divw(div_divw), .div_dividend(div_dividend),
    .div_divisor(div_divisor), .div_flush(div_flush), .div_out_valid(div_out_valid),
    .div_quotient(div_quotient), .div_remainder(div_remainder));

  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (div_valid) vcnt <= vcnt + 1;
    if (div_flush) fcnt <= fcnt + 1;
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic run_norm(input logic [1:0] s, input logic w, input logic [63:0] a, b, q, r,
                          exp, input string nm);
    int n, v0;
    v0 = vcnt;
    tests++; if (op_ready !== 1) begin fails++; $display("FAIL %s op_ready got %b want 1", nm, op_ready); end
    op_sel = s; op_word = w; src1 = a; src2 = b; op_valid = 1;
    tick; op_valid = 0;
    n = 0;
    while (!div_valid && n < 10) begin tick; n++; end
    tests++; if (n !== 1) begin fails++; $display("FAIL %s issue_delay got %0d want 1", nm, n); end
    tests++;
    if (div_signed !== ~s[0] || div_divw !== w || (!w && (div_dividend !== a || div_divisor !== b))) begin
      fails++; $display("FAIL %s div_req signed=%b divw=%b dd=%h dv=%h", nm, div_signed, div_divw, div_dividend, div_divisor);
    end
    tick;
    div_quotient = q; div_remainder = r; div_out_valid = 1;
    tick; div_out_valid = 0;
    tests++;
    if (res_valid !== 1 || res_data !== exp) begin
      fails++; $display("FAIL %s result valid=%b data=%h want 1/%h", nm, res_valid, res_data, exp);
    end
    tick;
    tests++; if (res_valid !== 0 || op_ready !== 1) begin fails++; $display("FAIL %s done_pulse valid=%b ready=%b want 0/1", nm, res_valid, op_ready); end
    tests++; if (vcnt - v0 !== 1) begin fails++; $display("FAIL %s div_valid_cycles got %0d want 1", nm, vcnt - v0); end
  endtask

  task automatic run_spec(input logic [1:0] s, input logic w, input logic [63:0] a, b, exp,
                          input string nm);
    int v0;
    v0 = vcnt;
    op_sel = s; op_word = w; src1 = a; src2 = b; op_valid = 1;
    tick; op_valid = 0;
    tests++; if (res_valid !== 0) begin fails++; $display("FAIL %s early_valid got %b want 0", nm, res_valid); end
    tick;
    tests++;
    if (res_valid !== 1 || res_data !== exp) begin
      fails++; $display("FAIL %s result valid=%b data=%h want 1/%h", nm, res_valid, res_data, exp);
    end
    tick;
    tests++; if (res_valid !== 0 || vcnt !== v0) begin fails++; $display("FAIL %s after valid=%b divv=%0d want 0/0", nm, res_valid, vcnt - v0); end
  endtask

  task automatic test_reset;
    #2;
    tests++;
    if (op_ready !== 1 || res_valid !== 0 || div_valid !== 0 || div_flush !== 0 || res_data !== 0) begin
      fails++; $display("FAIL reset rdy=%b rv=%b dv=%b df=%b rd=%h want 1/0/0/0/0", op_ready, res_valid, div_valid, div_flush, res_data);
    end
    rst_n = 1;
    tick;
  endtask

  task automatic test_normal;
    run_norm(2'b01, 0, 64'd100, 64'd7, 64'd14, 64'd2, 64'd14, "divu_100_7");
    run_norm(2'b11, 0, 64'd100, 64'd7, 64'd14, 64'd2, 64'd2, "remu_100_7");
    run_norm(2'b00, 0, -64'sd7, 64'd2, -64'sd3, -64'sd1, 64'hFFFF_FFFF_FFFF_FFFD, "div_m7_2");
    run_norm(2'b10, 0, -64'sd7, 64'd2, -64'sd3, -64'sd1, 64'hFFFF_FFFF_FFFF_FFFF, "rem_m7_2");
    run_norm(2'b00, 1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'h0000_0000_FFFF_FFFD, 64'h0, 64'hFFFF_FFFF_FFFF_FFFD, "divw_sext");
  endtask

  task automatic test_special;
    run_spec(2'b01, 0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, "divu_by0");
    run_spec(2'b11, 1, 64'd5, 64'hABCD_0000_0000_0000, 64'd5, "remuw_by0");
    run_spec(2'b00, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, "div_ovf");
    run_spec(2'b10, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, "rem_ovf");
    run_spec(2'b00, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, "divw_ovf");
  endtask

  task automatic test_flush;
    int f0, v0;
    f0 = fcnt;
    op_sel = 2'b01; op_word = 0; src1 = 64'd50; src2 = 64'd5; op_valid = 1;
    tick; op_valid = 0;
    tick; tick;
    flush = 1; #1;
    tests++; if (div_flush !== 1) begin fails++; $display("FAIL flush_wait div_flush got %b want 1", div_flush); end
    tick; flush = 0;
    tests++;
    if (op_ready !== 1 || res_valid !== 0 || fcnt - f0 !== 1) begin
      fails++; $display("FAIL flush_wait rdy=%b rv=%b pulses=%0d want 1/0/1", op_ready, res_valid, fcnt - f0);
    end
    div_quotient = 64'd10; div_out_valid = 1;
    tick; div_out_valid = 0;
    tests++;
    if (res_valid !== 0 || res_data !== 64'h0000_0000_8000_0000 && res_data !== 64'hFFFF_FFFF_8000_0000) begin
      fails++; $display("FAIL late_out rv=%b rd=%h want 0/FFFFFFFF80000000", res_valid, res_data);
    end
    v0 = vcnt;
    op_valid = 1; flush = 1; op_sel = 2'b01; src1 = 64'd8; src2 = 64'd2;
    tick; op_valid = 0; flush = 0;
    tests++; if (op_ready !== 1 || vcnt !== v0) begin fails++; $display("FAIL idle_flush rdy=%b divv=%0d want 1/0", op_ready, vcnt - v0); end
    op_sel = 2'b01; src1 = 64'd5; src2 = 64'd0; op_valid = 1;
    tick; op_valid = 0;
    tick; flush = 1; #1;
    tests++;
    if (res_valid !== 1 || res_data !== 64'hFFFF_FFFF_FFFF_FFFF || div_flush !== 0) begin
      fails++; $display("FAIL flush_done rv=%b rd=%h df=%b want 1/all-ones/0", res_valid, res_data, div_flush);
    end
    tick; flush = 0;
  endtask

  task automatic test_reset_mid;
    div_ready = 0;
    op_sel = 2'b01; src1 = 64'd40; src2 = 64'd4; op_valid = 1;
    tick; op_valid = 0;
    tick; tick;
    tests++; if (div_valid !== 1) begin fails++; $display("FAIL hold_issue div_valid got %b want 1", div_valid); end
    rst_n = 0; #1;
    tests++;
    if (div_valid !== 0 || op_ready !== 1 || res_data !== 0 || div_dividend !== 0) begin
      fails++; $display("FAIL reset_mid dv=%b rdy=%b rd=%h dd=%h want 0/1/0/0", div_valid, op_ready, res_data, div_dividend);
    end
    #2 rst_n = 1; div_ready = 1;
    tick;
    run_norm(2'b01, 0, 64'd9, 64'd3, 64'd3, 64'd0, 64'd3, "divu_9_3");
  endtask

  initial begin
    test_reset;
    test_normal;
    test_special;
    test_flush;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
